// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader: serial-to-packed assembler for a square signed 8-bit
// matrix of size 2..5. Elements arrive one per in_valid/in_ready handshake
// in row-major order and land in a packed 5x5 bus, element (r,c) at bits
// 8*(c+5*r) +: 8. The completed matrix is offered with matrix_valid and
// held until matrix_ack.
//
// Handshake rules: an element transfers on a rising clock edge where
// in_valid && in_ready; in_ready is high exactly while loading and does
// not depend on in_valid. The matrix transfers on a rising edge where
// matrix_valid && matrix_ack; matrix_valid stays high until then.
//
// FSM state is visible on the outputs: busy=0 means IDLE, in_ready=1 means
// LOAD, matrix_valid=1 means DONE.
//
// Optional build macro: IDENTITY_PAD_EN -- when defined, unused diagonal
// positions (k,k), k>=size, are padded with 1 instead of 0.

module mpu_matrix_loader (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic signed [7:0]  size,
  input  logic signed [7:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [199:0]       matrix,
  output logic signed [7:0]  matrix_size,
  output logic               matrix_valid,
  input  logic               matrix_ack,
  output logic               busy,
  output logic               error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [2:0]   row;
  logic [2:0]   col;
  logic [2:0]   last_idx;
  logic         size_legal;
  logic         handshake;
  logic         last_col;
  logic         last_elem;
  logic [4:0]   elem_idx;
  logic [7:0]   elem_base;
  logic [199:0] pad;

  assign size_legal = (size >= 8'sd2) && (size <= 8'sd5);
  assign last_idx   = matrix_size[2:0] - 3'd1;
  assign last_col   = (col == last_idx);
  assign last_elem  = last_col && (row == last_idx);
  assign handshake  = in_valid && in_ready;
  assign elem_idx   = {2'b00, col} + 5'd5 * {2'b00, row};
  assign elem_base  = {elem_idx, 3'b000};

`ifdef IDENTITY_PAD_EN
  // Identity padding so a 5x5 determinant equals that of the loaded block.
  always_comb begin
    pad = '0;
    for (int k = 0; k < 5; k++) begin
      if (3'(k) >= size[2:0]) begin
        pad[48*k +: 8] = 8'd1;
      end
    end
  end
`else
  assign pad = '0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    matrix_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && size_legal) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (handshake && last_elem) begin
          state_next = DONE;
        end
      end
      DONE: begin
        matrix_valid = 1'b1;
        if (matrix_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: size latch, matrix writes, row/col counters, error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      row         <= 3'd0;
      col         <= 3'd0;
      matrix      <= '0;
      matrix_size <= 8'sd0;
      error       <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (size_legal) begin
              matrix_size <= size;
              matrix      <= pad;
              row         <= 3'd0;
              col         <= 3'd0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (handshake) begin
            matrix[elem_base +: 8] <= in_data;
            if (last_col) begin
              col <= 3'd0;
              row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
